// File: rtl/cpu_pkg.sv
// Shared CPU datapath definitions: native word width and word type
// used as the default shape of datapath registers.
package cpu_pkg;

   localparam int DATA_WIDTH = 64;

   typedef logic [DATA_WIDTH-1:0] word_t;

   localparam word_t WORD_ZERO = '0;

endpackage : cpu_pkg

// File: rtl/flop_reset_stage.sv
// One register stage with asynchronous active-low reset; the building
// block of flop_reset.
module flop_reset_stage
   import cpu_pkg::*;
#(
   parameter int               WIDTH     = DATA_WIDTH,
   parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   logic [WIDTH-1:0] data_d;
   logic [WIDTH-1:0] data_q;

   always_comb begin
      data_d = d;
   end

   // NOTE: reset sits in the sensitivity list so a falling reset clears the
   // stage at once; a reset that is still low at a clk edge beats the capture.
   // NOTE: non-blocking assignment keeps every stage sampling its pre-edge
   // input, which is what makes a chain of these behave as a delay line.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         data_q <= RESET_VAL;
      end else begin
         data_q <= data_d;
      end
   end

   assign q = data_q;

endmodule : flop_reset_stage

// File: rtl/flop_reset.sv
// Parameterised register ("flopr") with asynchronous active-low reset;
// STAGES > 1 chains identical stages into a fixed-latency delay line.
module flop_reset
   import cpu_pkg::*;
#(
   parameter int               WIDTH     = DATA_WIDTH,
   parameter logic [WIDTH-1:0] RESET_VAL = '0,
   parameter int               STAGES    = 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   if (WIDTH < 1) begin : g_bad_width
      $fatal(1, "flop_reset: WIDTH must be >= 1");
   end
   if (STAGES < 1) begin : g_bad_stages
      $fatal(1, "flop_reset: STAGES must be >= 1");
   end

   // chain[i] feeds stage i; chain[STAGES] is the last stage's output.
   logic [WIDTH-1:0] chain [STAGES+1];

   assign chain[0] = d;

   for (genvar i = 0; i < STAGES; i++) begin : g_stage
      flop_reset_stage #(
         .WIDTH     (WIDTH),
         .RESET_VAL (RESET_VAL)
      ) u_stage (
         .clk   (clk),
         .reset (reset),
         .d     (chain[i]),
         .q     (chain[i+1])
      );
   end

   assign q = chain[STAGES];

`ifndef SYNTHESIS
   // Counts capture edges since reset released, so the latency check only
   // fires once every stage holds real data.
   int fill_d;
   int fill_q;

   always_comb begin
      fill_d = (fill_q < STAGES) ? fill_q + 1 : fill_q;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         fill_q <= 0;
      end else begin
         fill_q <= fill_d;
      end
   end

   a_reset_val : assert property (@(posedge clk) !reset |-> (q == RESET_VAL));
   a_latency   : assert property (@(posedge clk)
                                  (reset && fill_q == STAGES) |-> (q == $past(d, STAGES)));
`endif

endmodule : flop_reset

// File: tb/tb_flop_reset.sv
// Self-checking bench for flop_reset: a plain flop (STAGES=1) and a
// three-stage delay line with a non-zero reset value, driven in lockstep.
module tb_flop_reset;
   import cpu_pkg::*;

   localparam int    S3  = 3;
   localparam word_t RV3 = 64'hDEAD;
   localparam word_t ONES = 64'hFFFF_FFFF_FFFF_FFFF;

   typedef struct {
      logic  rst;
      word_t d;
      word_t exp1;   // q of the plain flop after the edge that samples this row
   } vec_t;

   logic  clk = 1'b0;
   logic  reset;
   word_t d;
   word_t q1;
   word_t q3;

   int total = 0;
   int bad   = 0;

   vec_t  tbl [$];
   word_t exp_q [$];   // scoreboard for the plain flop
   word_t pipe [S3];   // reference contents of the three-stage line

   always #10 clk = ~clk;

   flop_reset #(
      .WIDTH (DATA_WIDTH)
   ) u_dut1 (
      .clk   (clk),
      .reset (reset),
      .d     (d),
      .q     (q1)
   );

   flop_reset #(
      .WIDTH     (DATA_WIDTH),
      .RESET_VAL (RV3),
      .STAGES    (S3)
   ) u_dut3 (
      .clk   (clk),
      .reset (reset),
      .d     (d),
      .q     (q3)
   );

   task automatic check(input string name, input word_t act, input word_t exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic void add(input logic rst, input word_t din, input word_t exp1);
      vec_t v;
      v.rst  = rst;
      v.d    = din;
      v.exp1 = exp1;
      tbl.push_back(v);
   endfunction

   task automatic clear_pipe();
      for (int i = 0; i < S3; i++) pipe[i] = RV3;
   endtask

   task automatic shift_pipe(input word_t din);
      for (int i = S3 - 1; i > 0; i--) pipe[i] = pipe[i-1];
      pipe[0] = din;
   endtask

   // Drive one row 2 ns after negedge, check 1 ns before the next posedge.
   task automatic tick(input string name, input logic rst, input word_t din, input word_t exp1);
      word_t want1;
      @(negedge clk);
      #2;
      reset = rst;
      d     = din;
      want1 = exp_q.pop_front();
      if (!rst) begin
         want1 = WORD_ZERO;
         clear_pipe();
      end
      exp_q.push_back(exp1);
      #7;
      check({name, "_q1"}, q1, want1);
      check({name, "_q3"}, q3, pipe[S3-1]);
      if (rst) shift_pipe(din);
   endtask

   task automatic run_rows(input string name, input int first, input int last);
      for (int i = first; i <= last; i++) begin
         tick(name, tbl[i].rst, tbl[i].d, tbl[i].exp1);
      end
   endtask

   // 2 ns reset pulse between edges; the next edge must load din.
   task automatic reset_pulse(input word_t din);
      word_t want1;
      @(negedge clk);
      #1;
      want1 = exp_q.pop_front();
      check("pre_pulse_q1", q1, want1);
      check("pre_pulse_q3", q3, pipe[S3-1]);
      #1 d = din;
      #2 reset = 1'b0;
      #1;
      check("pulse_now_q1", q1, WORD_ZERO);
      check("pulse_now_q3", q3, RV3);
      #1 reset = 1'b1;
      #3;
      check("pulse_after_q1", q1, WORD_ZERO);
      check("pulse_after_q3", q3, RV3);
      clear_pipe();
      exp_q.push_back(din);
      shift_pipe(din);
   endtask

   initial begin
      int p_pwr_end, p_strm_a_end, p_strm_b_end, p_wide_end, p_s3_end;

      // Power-up: reset held, d nonzero
      for (int i = 0; i < 3; i++) add(1'b0, 64'h5, WORD_ZERO);
      p_pwr_end = tbl.size() - 1;
      // Stream 0..7 up to the async pulse
      for (int i = 0; i < 8; i++) add(1'b1, word_t'(i), word_t'(i));
      p_strm_a_end = tbl.size() - 1;
      // Stream resumes after the pulse (8 is loaded by the pulse itself)
      add(1'b1, 64'd9, 64'd9);
      add(1'b1, 64'd0, 64'd0);
      p_strm_b_end = tbl.size() - 1;
      // Full-width patterns
      add(1'b1, 64'h8000_0000_0000_0001, 64'h8000_0000_0000_0001);
      add(1'b1, 64'h7FFF_FFFF_FFFF_FFFE, 64'h7FFF_FFFF_FFFF_FFFE);
      add(1'b1, WORD_ZERO, WORD_ZERO);
      p_wide_end = tbl.size() - 1;
      // Three-stage line: reset, impulse, refill, mid-stream flush
      add(1'b0, 64'h77, WORD_ZERO);
      add(1'b1, 64'd1, 64'd1);
      for (int i = 0; i < 4; i++) add(1'b1, WORD_ZERO, WORD_ZERO);
      add(1'b1, 64'd2, 64'd2);
      add(1'b1, 64'd3, 64'd3);
      add(1'b0, 64'd4, WORD_ZERO);
      for (int i = 0; i < 4; i++) add(1'b1, WORD_ZERO, WORD_ZERO);
      p_s3_end = tbl.size() - 1;

      reset = 1'b1;
      d     = 64'h5;
      #1 reset = 1'b0;
      clear_pipe();
      exp_q.push_back(WORD_ZERO);
      #1;
      check("pwr_t0_q1", q1, WORD_ZERO);
      check("pwr_t0_q3", q3, RV3);

      run_rows("pwr", 0, p_pwr_end);
      @(posedge clk);
      #1;
      check("pwr_edge_q1", q1, WORD_ZERO);
      check("pwr_edge_q3", q3, RV3);

      run_rows("stream", p_pwr_end + 1, p_strm_a_end);
      reset_pulse(64'd8);
      run_rows("stream", p_strm_a_end + 1, p_strm_b_end);

      // Reset released exactly on a posedge: that edge must not capture.
      tick("coinc_hold", 1'b0, ONES, WORD_ZERO);
      @(posedge clk);
      // Non-blocking so the release lands after the flops have seen this edge.
      reset <= 1'b1;
      #1;
      check("coinc_edge_q1", q1, WORD_ZERO);
      check("coinc_edge_q3", q3, RV3);
      tick("coinc_next", 1'b1, ONES, ONES);
      tick("coinc_cap", 1'b1, WORD_ZERO, WORD_ZERO);

      run_rows("wide", p_strm_b_end + 1, p_wide_end);
      run_rows("s3", p_wide_end + 1, p_s3_end);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule : tb_flop_reset
